// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide memory bus between instruction fetch and the load/store buffer,
// serialising each request into byte transfers and reassembling little-endian read words.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d, n, nxt;
    logic [1:0]            size_q, size_d, lane;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
    logic [31:0]           wdata_q, wdata_d, buf_q, buf_d;
    logic [31:0]           if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
    logic [7:0]            dout_q, dout_d;
    logic                  wr_q, wr_d, if_done_q, if_done_d, ls_done_q, ls_done_d;
    logic                  last_ls_q, last_ls_d, take_ls, io_stall;
    assign n        = size_q == 2'd0 ? 3'd1 : size_q == 2'd1 ? 3'd2 : 3'd4;
    assign nxt      = cnt_q + 3'd1;
    assign lane     = cnt_q[1:0] - 2'd1;
    assign io_stall = state_q == LS_WR && mem_a_q[17:16] == 2'b11 && io_buffer_full;
    assign mem_wr   = wr_q & rdy_in & ~io_stall;
    assign mem_a    = mem_a_q;
    assign mem_dout = dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        addr_d     = addr_q;
        mem_a_d    = mem_a_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        dout_d     = dout_q;
        wr_d       = wr_q;
        last_ls_d  = last_ls_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        take_ls    = 1'b0;
        if (state_q == IDLE) begin
            // a done pulse in flight forces one bubble so the requester can drop req
            if (!flush && !if_done_q && !ls_done_q && (if_req || ls_req)) begin
                take_ls   = ls_req && (!if_req || !last_ls_q);
                last_ls_d = take_ls;
                cnt_d     = '0;
                buf_d     = '0;
                addr_d    = take_ls ? ls_addr : if_addr;
                mem_a_d   = addr_d;
                size_d    = take_ls ? ls_size : 2'd2;
                wdata_d   = ls_wdata;
                dout_d    = ls_wdata[7:0];
                wr_d      = take_ls && ls_wr;
                state_d   = !take_ls ? IF_RD : ls_wr ? LS_WR : LS_RD;
            end
        end else if (state_q == LS_WR) begin
            if (!io_stall) begin
                if (nxt < n) begin
                    cnt_d   = nxt;
                    mem_a_d = addr_q + ADDR_WIDTH'(nxt);
                    dout_d  = wdata_q[{nxt[1:0], 3'b000} +: 8];
                end else begin
                    wr_d      = 1'b0;
                    ls_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
        end else if (flush) begin
            state_d = IDLE;
            mem_a_d = '0;
        end else begin
            // cnt keeps counting past the last address; capture lags the address by two edges
            cnt_d = nxt;
            if (nxt < n) mem_a_d = addr_q + ADDR_WIDTH'(nxt);
            if (cnt_q != 3'd0) buf_d[{lane, 3'b000} +: 8] = mem_din;
            if (cnt_q == n) begin
                state_d    = IDLE;
                if_done_d  = state_q == IF_RD;
                ls_done_d  = state_q == LS_RD;
                if_data_d  = state_q == IF_RD ? buf_d : if_data_q;
                ls_rdata_d = state_q == LS_RD ? buf_d : ls_rdata_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            size_q     <= '0;
            addr_q     <= '0;
            mem_a_q    <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            last_ls_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            mem_a_q    <= mem_a_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            last_ls_q  <= last_ls_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scenario tasks drive the arbiter against a byte RAM model with one-cycle read latency;
// expected read words and bus writes are queued when a request is issued and compared on completion.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0, io_buffer_full = 1'b0;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_wr = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [7:0]  mem_din = '0, mem_dout;
    typedef struct packed {logic is_ls; logic [31:0] data;} rd_t;
    typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;
    rd_t         exp_rd[$];
    wr_t         exp_wr[$], obs_wr[$];
    logic [31:0] tr_a[0:40];
    logic        tr_wr[0:40];
    int          errors = 0, checks = 0;
    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );
    always #5 clk = ~clk;
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102, 32'h103: return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction
    function automatic logic [31:0] rd_word(input logic [31:0] a, input int n);
        logic [31:0] w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ram_byte(a + i);
        return w;
    endfunction
    always @(posedge clk) mem_din <= ram_byte(mem_a);
    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask
    // Issues one load/store and records the bus trace until ls_done (bounded); lat = 0 on timeout.
    task automatic run_ls(input logic wr, input logic [1:0] size, input logic [31:0] addr, wdata,
                          input int io_from, io_to, rdy_from, rdy_to, flush_from, output int lat);
        obs_wr.delete();
        @(negedge clk);
        ls_req = 1'b1; ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            io_buffer_full = c >= io_from && c < io_to;
            rdy_in = !(c >= rdy_from && c < rdy_to);
            flush = c >= flush_from;
            #1;
            tr_a[c] = mem_a;
            tr_wr[c] = mem_wr;
            if (mem_wr) obs_wr.push_back('{mem_a, mem_dout});
            if (ls_done) lat = c;
        end
        ls_req = 1'b0; flush = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
    endtask
    task automatic test_reset;
        rst_in = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        idle(3);
        #1;
        checks++; if ({if_done, ls_done, mem_wr} !== 3'b000) begin errors++; $display("FAIL reset_strobes got=%b exp=000", {if_done, ls_done, mem_wr}); end
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
        checks++; if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", if_data, ls_rdata); end
        if_req = 1'b0; rst_in = 1'b0;
        idle(2);
    endtask
    task automatic test_fetch;
        rd_t e;
        int lat = 0;
        idle(2);
        @(negedge clk);
        if_addr = 32'h100; if_req = 1'b1;
        exp_rd.push_back('{1'b0, 32'h00000513});
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk); #1;
            if (c <= 4) begin
                checks++; if (mem_a !== 32'h100 + c - 1) begin errors++; $display("FAIL fetch_addr c=%0d got=%h exp=%h", c, mem_a, 32'h100 + c - 1); end
            end
            if (if_done) begin lat = c; if_req = 1'b0; end
        end
        if_req = 1'b0;
        e = exp_rd.pop_front();
        checks++; if (lat != 6) begin errors++; $display("FAIL fetch_latency got=%0d exp=6", lat); end
        checks++; if (if_data !== e.data) begin errors++; $display("FAIL fetch_data got=%h exp=%h", if_data, e.data); end
        @(negedge clk); #1;
        checks++; if (if_done !== 1'b0 || if_data !== e.data) begin errors++; $display("FAIL fetch_pulse done=%b data=%h exp=0/%h", if_done, if_data, e.data); end
    endtask
    task automatic test_loads;
        logic [31:0] la[3] = '{32'h7F, 32'h1232, 32'h4444};
        rd_t e;
        int lat, n;
        for (int i = 0; i < 3; i++) begin
            idle(2);
            n = i == 0 ? 1 : i == 1 ? 2 : 4;
            exp_rd.push_back('{1'b1, rd_word(la[i], n)});
            run_ls(1'b0, 2'(i), la[i], 32'hFFFF_FFFF, 99, 99, 99, 99, 99, lat);
            e = exp_rd.pop_front();
            checks++; if (lat != n + 2) begin errors++; $display("FAIL load_latency size=%0d got=%0d exp=%0d", i, lat, n + 2); end
            checks++; if (ls_rdata !== e.data) begin errors++; $display("FAIL load_data size=%0d got=%h exp=%h", i, ls_rdata, e.data); end
            checks++; if (tr_a[1] !== la[i] || tr_a[n] !== la[i] + n - 1) begin errors++; $display("FAIL load_addr size=%0d got=%h..%h exp=%h..%h", i, tr_a[1], tr_a[n], la[i], la[i] + n - 1); end
        end
    endtask
    task automatic test_stores;
        logic [31:0] sa[3] = '{32'h2001, 32'h2100, 32'h2200};
        logic [31:0] sd[3] = '{32'h0000_00AB, 32'h1234_BEEF, 32'hCAFE_F00D};
        wr_t e, o;
        int lat, n;
        for (int i = 0; i < 3; i++) begin
            idle(2);
            n = i == 0 ? 1 : i == 1 ? 2 : 4;
            for (int k = 0; k < n; k++) exp_wr.push_back('{sa[i] + k, sd[i][8*k +: 8]});
            run_ls(1'b1, 2'(i), sa[i], sd[i], 99, 99, 99, 99, 99, lat);
            checks++; if (lat != n + 1) begin errors++; $display("FAIL store_latency size=%0d got=%0d exp=%0d", i, lat, n + 1); end
            while (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                o = obs_wr.size() > 0 ? obs_wr.pop_front() : '0;
                checks++; if (o !== e) begin errors++; $display("FAIL store_byte size=%0d got=%h:%h exp=%h:%h", i, o.a, o.d, e.a, e.d); end
            end
            checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL store_extra size=%0d got=%0d extra writes exp=0", i, obs_wr.size()); end
        end
    endtask
    task automatic test_io_stall;
        wr_t e, o;
        int lat;
        idle(2);
        for (int k = 0; k < 4; k++) exp_wr.push_back('{32'h30000 + k, 8'(8'h11 * (k + 1))});
        run_ls(1'b1, 2'd2, 32'h30000, 32'h4433_2211, 2, 5, 99, 99, 1, lat);
        checks++; if (lat != 8) begin errors++; $display("FAIL io_latency got=%0d exp=8", lat); end
        for (int c = 2; c <= 4; c++) begin
            checks++; if (tr_wr[c] !== 1'b0 || tr_a[c] !== 32'h30001) begin errors++; $display("FAIL io_hold c=%0d wr=%b a=%h exp=0/30001", c, tr_wr[c], tr_a[c]); end
        end
        checks++; if (obs_wr.size() != 4) begin errors++; $display("FAIL io_write_count got=%0d exp=4", obs_wr.size()); end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = obs_wr.size() > 0 ? obs_wr.pop_front() : '0;
            checks++; if (o !== e) begin errors++; $display("FAIL io_byte got=%h:%h exp=%h:%h", o.a, o.d, e.a, e.d); end
        end
    endtask
    task automatic test_rdy_stall;
        rd_t e;
        int lat;
        idle(2);
        exp_rd.push_back('{1'b1, rd_word(32'h40, 2)});
        run_ls(1'b0, 2'd1, 32'h40, 32'h0, 99, 99, 1, 3, 99, lat);
        e = exp_rd.pop_front();
        checks++; if (lat != 6) begin errors++; $display("FAIL rdy_load_latency got=%0d exp=6", lat); end
        checks++; if (tr_a[2] !== 32'h40 || tr_a[3] !== 32'h40 || tr_a[4] !== 32'h41) begin errors++; $display("FAIL rdy_load_addr got=%h,%h,%h exp=40,40,41", tr_a[2], tr_a[3], tr_a[4]); end
        checks++; if (ls_rdata !== e.data) begin errors++; $display("FAIL rdy_load_data got=%h exp=%h", ls_rdata, e.data); end
        idle(2);
        run_ls(1'b1, 2'd0, 32'h600, 32'h0000_005C, 99, 99, 1, 2, 99, lat);
        checks++; if (tr_wr[1] !== 1'b0) begin errors++; $display("FAIL rdy_store_gate got=%b exp=0", tr_wr[1]); end
        checks++; if (lat != 3 || tr_wr[2] !== 1'b1 || tr_a[2] !== 32'h600) begin errors++; $display("FAIL rdy_store_resume lat=%0d wr=%b a=%h exp=3/1/600", lat, tr_wr[2], tr_a[2]); end
    endtask
    task automatic test_round_robin;
        rd_t e;
        int dn = 0, prev = 0;
        rst_in = 1'b1;
        idle(2);
        rst_in = 1'b0;
        exp_rd.push_back('{1'b1, rd_word(32'h400, 4)});
        exp_rd.push_back('{1'b0, rd_word(32'h300, 4)});
        exp_rd.push_back('{1'b1, rd_word(32'h400, 4)});
        @(negedge clk);
        if_addr = 32'h300; if_req = 1'b1;
        ls_addr = 32'h400; ls_wr = 1'b0; ls_size = 2'd2; ls_req = 1'b1;
        for (int c = 1; c <= 60 && dn < 3; c++) begin
            @(negedge clk); #1;
            if (if_done || ls_done) begin
                e = exp_rd.pop_front();
                checks++; if ({if_done, ls_done} !== {!e.is_ls, e.is_ls}) begin errors++; $display("FAIL rr_order n=%0d got if/ls=%b%b exp=%b%b", dn, if_done, ls_done, !e.is_ls, e.is_ls); end
                checks++; if ((e.is_ls ? ls_rdata : if_data) !== e.data) begin errors++; $display("FAIL rr_data n=%0d got=%h exp=%h", dn, e.is_ls ? ls_rdata : if_data, e.data); end
                checks++; if (c - prev != (dn == 0 ? 6 : 7)) begin errors++; $display("FAIL rr_spacing n=%0d got=%0d exp=%0d", dn, c - prev, dn == 0 ? 6 : 7); end
                prev = c;
                dn++;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        checks++; if (dn != 3) begin errors++; $display("FAIL rr_count got=%0d exp=3", dn); end
        exp_rd.delete();
    endtask
    task automatic test_flush;
        rd_t e;
        int lat = 0;
        logic saw_if = 1'b0;
        logic [31:0] last_if;
        idle(2);
        last_if = if_data;
        exp_rd.push_back('{1'b1, rd_word(32'h55, 1)});
        @(negedge clk);
        if_addr = 32'h100; if_req = 1'b1;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin ls_addr = 32'h55; ls_wr = 1'b0; ls_size = 2'd0; ls_req = 1'b1; end
            if (c == 2) begin flush = 1'b1; if_req = 1'b0; end
            if (c == 3) flush = 1'b0;
            #1;
            saw_if |= if_done;
            if (c == 3) begin
                checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL flush_addr got=%h exp=0", mem_a); end
            end
            if (c == 4) begin
                checks++; if (mem_a !== 32'h55) begin errors++; $display("FAIL flush_regrant got=%h exp=55", mem_a); end
            end
            if (ls_done) begin lat = c; ls_req = 1'b0; end
        end
        ls_req = 1'b0;
        e = exp_rd.pop_front();
        checks++; if (lat != 6) begin errors++; $display("FAIL flush_ls_latency got=%0d exp=6", lat); end
        checks++; if (ls_rdata !== e.data) begin errors++; $display("FAIL flush_ls_data got=%h exp=%h", ls_rdata, e.data); end
        idle(2);
        @(negedge clk);
        if_addr = 32'h104; if_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            flush = c == 5;
            if (c == 6) if_req = 1'b0;
            #1;
            saw_if |= if_done;
            if (c == 6) begin
                checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL flush_last_addr got=%h exp=0", mem_a); end
            end
        end
        flush = 1'b0; if_req = 1'b0;
        checks++; if (saw_if !== 1'b0) begin errors++; $display("FAIL flush_no_done got=%b exp=0", saw_if); end
        checks++; if (if_data !== last_if) begin errors++; $display("FAIL flush_if_data_hold got=%h exp=%h", if_data, last_if); end
    endtask
    initial begin
        test_reset;
        test_fetch;
        test_loads;
        test_stores;
        test_io_stall;
        test_rdy_stall;
        test_round_robin;
        test_flush;
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory controller that shares the 8-bit RAM/IO bus between the instruction-cache refill path and the load/store buffer. It serialises each request into byte-wide bus transfers, reassembles read data into 32-bit little-endian words, and returns a one-cycle completion pulse. Fetches and speculative loads are aborted on pipeline flush; committed stores always run to completion. It sits between the cache/LSB and the top-level memory pins.

## Interface
- ADDR_WIDTH, 32, byte address width
- clk  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- flush  in  1  misprediction flush from ROB
- if_req  in  1  instruction word read request; held until if_done
- if_addr  in  ADDR_WIDTH  word address; bits [1:0] = 0
- if_done  out  1  one-cycle pulse; if_data valid this cycle only
- if_data  out  32  fetched instruction, little-endian
- ls_req  in  1  load/store request; held until ls_done
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  0 = byte, 1 = half, 2 = word
- ls_addr  in  ADDR_WIDTH  byte address
- ls_wdata  in  32  store data; low bytes are used first
- ls_done  out  1  one-cycle completion pulse
- ls_rdata  out  32  load data, zero-extended; LSB performs sign extension
- mem_din  in  8  RAM read byte, valid one cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  ADDR_WIDTH  bus address
- mem_wr  out  1  write strobe, gated combinationally with rdy_in
- io_buffer_full  in  1  UART buffer full

## Operation
- States: IDLE, IF_RD, LS_RD, LS_WR. Byte count is N = 4 for fetches and 1/2/4 for loads and stores, per ls_size. A 3-bit counter cnt tracks progress.
- IDLE grant:
  - No grant when flush = 1, or when if_done or ls_done is high in the current cycle. This guarantees one bubble so a requester can drop req.
  - With only one request pending, grant it.
  - With both pending, grant the requester not granted last (round-robin). last_grant resets to IF, so LS wins the first tie.
- Grant edge: latch address, size and wdata. Drive mem_a = addr and set cnt = 0.
  - For a store, also drive mem_wr = 1 and mem_dout = wdata[7:0].
- Read (IF_RD / LS_RD), each edge:
  - Drive mem_a = addr + cnt + 1 while cnt + 1 < N.
  - From the second edge after grant onward, capture mem_din into byte lane (number of captures so far).
  - On the capture of lane N-1: set done = 1, put the assembled word on the data output, and go to IDLE.
- Write (LS_WR), each edge:
  - Advance to the next byte: mem_a = addr + k, mem_dout = wdata[8k+7:8k].
  - After byte N-1 has been driven for one cycle: mem_wr = 0, ls_done = 1, go to IDLE.
- IO stall: if addr[17:16] == 2'b11 and io_buffer_full = 1 during a write cycle, keep mem_wr = 0 and hold cnt, mem_a and mem_dout. Resume when io_buffer_full = 0.
- Flush:
  - In IF_RD or LS_RD, the next edge returns to IDLE, mem_a = 0, and no done pulse is issued. This holds even if that edge would have completed the read.
  - LS_WR ignores flush.
- rdy_in = 0: no register changes and mem_wr output is 0. Resuming continues exactly where it stopped.
- Reset values: state IDLE, cnt 0, all outputs 0, last_grant = IF.

## Timing
- Request sampled high at edge E0 (grant):
  - N-byte read: done high in the cycle after E(N+1). A word fetch therefore completes in 5 cycles.
  - N-byte write: done high in the cycle after E(N), assuming no IO stall.
- Bus addresses are issued on consecutive cycles; there are no gaps except for rdy_in low or an IO stall.
- done pulses last exactly 1 cycle. if_data and ls_rdata hold their value until the next completion.
- Earliest re-grant is 2 edges after done is set, because of the bubble cycle.

## Test plan
- Fetch, if_addr=0x100, RAM bytes 13 05 00 00 -> mem_a = 0x100..0x103 on 4 consecutive cycles; if_data = 0x00000513 with if_done 5 cycles after grant.
- Byte store, ls_addr=0x2001, ls_wdata=0xAB, size 0 -> one cycle of mem_wr = 1, mem_a = 0x2001, mem_dout = 0xAB; ls_done on the next cycle.
- if_req and ls_req held continuously after reset -> grants alternate LS, IF, LS; each grant is preceded by exactly one idle cycle after done.
- Flush asserted 2 cycles into a fetch -> state returns to IDLE, no if_done; a pending ls_req is granted 1 cycle after flush drops.
- Word store to 0x30000 with io_buffer_full high for 3 cycles mid-store -> mem_wr low for those 3 cycles, address held; 4 total write cycles, then ls_done.
- rdy_in low for 2 cycles mid-load (half, 0x40) -> mem_a frozen and mem_wr = 0; ls_rdata = {16'h0, byte41, byte40} delivered 2 cycles later than nominal.
